// File: rtl/sum_bcd_display.sv
// sum_bcd_display: iterative binary-to-BCD converter (shift-and-add-3, one
// bit per clock) driving active-low seven-segment patterns for HEX displays.
// A valid/ready handshake accepts a new sum only while the converter is idle.
// Optional build macro: SUM_BCD_LEADING_ZERO_BLANK_EN blanks leading zero
// digits above digit 0, both in the result and in the reset pattern.
module sum_bcd_display #(
  parameter int IN_W   = 6,
  parameter int DIGITS = 2
) (
  input  logic                  CLOCK_50,
  input  logic                  RST,
  input  logic                  in_valid,
  input  logic [IN_W-1:0]       in_data,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_W + 1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  // The largest binary input must fit in the available decimal digits.
  if (((64'd1 << IN_W) - 64'd1) > (pow10(DIGITS) - 64'd1)) begin : g_bad_params
    $fatal(1, "sum_bcd_display: DIGITS too small for IN_W");
  end

  // Active-low gfedcba pattern for one BCD digit; non-decimal codes blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Pattern shown while in reset: every digit "0", or only digit 0 when
  // leading-zero blanking is built in.
  function automatic logic [7*DIGITS-1:0] reset_seg();
    logic [7*DIGITS-1:0] r;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
`ifdef SUM_BCD_LEADING_ZERO_BLANK_EN
      r[7*k +: 7] = (k == 0) ? 7'b1000000 : 7'b1111111;
`else
      r[7*k +: 7] = 7'b1000000;
`endif
    end
    return r;
  endfunction

  localparam logic [7*DIGITS-1:0] SEG_RST = reset_seg();

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_r, state_s;
  logic [IN_W-1:0]       shreg_r, shreg_s;
  logic [BW-1:0]         scratch_r, scratch_s;
  logic [BW-1:0]         adj_s;
  logic [CW-1:0]         cnt_r, cnt_s;
  logic [7*DIGITS-1:0]   seg_dec_s;
  logic                  out_valid_r;
  logic [BW-1:0]         bcd_r;
  logic [7*DIGITS-1:0]   seg_r;

  // Next-state logic: load on accept, add-3 then shift per SHIFT cycle.
  always_comb begin
    state_s   = state_r;
    shreg_s   = shreg_r;
    scratch_s = scratch_r;
    cnt_s     = cnt_r;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch_r[4*k +: 4] >= 4'd5) adj_s[4*k +: 4] = scratch_r[4*k +: 4] + 4'd3;
      else                             adj_s[4*k +: 4] = scratch_r[4*k +: 4];
    end
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          shreg_s   = in_data;
          scratch_s = '0;
          cnt_s     = CW'(IN_W);
          state_s   = SHIFT;
        end else begin
          state_s   = IDLE;
        end
      end
      SHIFT: begin
        {scratch_s, shreg_s} = {adj_s, shreg_r} << 32'd1;
        cnt_s = cnt_r - CW'(1);
        if (cnt_r == CW'(1)) state_s = DONE;
        else                 state_s = SHIFT;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Decode the finished scratch value into per-digit segment patterns.
  always_comb begin
`ifdef SUM_BCD_LEADING_ZERO_BLANK_EN
    logic lead_v;
    lead_v = 1'b1;
`endif
    seg_dec_s = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
`ifdef SUM_BCD_LEADING_ZERO_BLANK_EN
      if (k != 0 && lead_v && scratch_r[4*k +: 4] == 4'd0) seg_dec_s[7*k +: 7] = 7'b1111111;
      else                                                 seg_dec_s[7*k +: 7] = seg7(scratch_r[4*k +: 4]);
      lead_v = lead_v & (scratch_r[4*k +: 4] == 4'd0);
`else
      seg_dec_s[7*k +: 7] = seg7(scratch_r[4*k +: 4]);
`endif
    end
  end

  // Converter state registers.
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state_r   <= IDLE;
      shreg_r   <= '0;
      scratch_r <= '0;
      cnt_r     <= '0;
    end else begin
      state_r   <= state_s;
      shreg_r   <= shreg_s;
      scratch_r <= scratch_s;
      cnt_r     <= cnt_s;
    end
  end

  // Result registers: updated only when leaving DONE, with a one-cycle strobe.
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      out_valid_r <= 1'b0;
      bcd_r       <= '0;
      seg_r       <= SEG_RST;
    end else if (state_r == DONE) begin
      out_valid_r <= 1'b1;
      bcd_r       <= scratch_r;
      seg_r       <= seg_dec_s;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  // Handshake status is gated by RST so it drops for the whole reset window.
  assign in_ready  = (state_r == IDLE) && !RST;
  assign busy      = (state_r != IDLE) && !RST;
  assign out_valid = out_valid_r;
  assign bcd       = bcd_r;
  assign seg       = seg_r;

endmodule

// File: tb/tb_sum_bcd_display.sv
// Scoreboard bench for sum_bcd_display: stimulus pushes hand-computed
// results, a negedge monitor pops and compares on every out_valid pulse.
module tb_sum_bcd_display;

  logic        CLOCK_50 = 1'b0;
  logic        RST      = 1'b1;
  logic        in_valid = 1'b0;
  logic [5:0]  in_data  = 6'd0;
  logic        in_ready, busy, out_valid;
  logic [7:0]  bcd;
  logic [13:0] seg;

`ifdef SUM_BCD_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] UZ = 7'b1111111;
`else
  localparam logic [6:0] UZ = 7'b1000000;
`endif

  sum_bcd_display #(.IN_W(6), .DIGITS(2)) dut (
    .CLOCK_50 (CLOCK_50),
    .RST      (RST),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .out_valid(out_valid),
    .bcd      (bcd),
    .seg      (seg)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  logic [21:0] sb_q[$];   // {bcd[7:0], seg[13:0]}
  logic [21:0] mon_e;
  int          ov_cyc[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic        prev_ov  = 1'b0;
  int          acc, n0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest expected result.
  always @(negedge CLOCK_50) begin
    if (!RST && out_valid === 1'b1) begin
      ov_cyc.push_back(cyc);
      chk("out_valid_single_cycle", {31'd0, prev_ov}, 32'd0);
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got pulse with bcd=%0h expected none", bcd);
      end else begin
        mon_e = sb_q.pop_front();
        chk("bcd", {24'd0, bcd}, {24'd0, mon_e[21:14]});
        chk("seg", {18'd0, seg}, {18'd0, mon_e[13:0]});
      end
    end
    prev_ov <= out_valid;
  end

  task automatic wait_ready();
    for (int i = 0; i < 50 && in_ready !== 1'b1; i++) @(negedge CLOCK_50);
    if (in_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_ready: got in_ready=%b expected 1 within 50 cycles", in_ready);
    end
  endtask

  task automatic send(input logic [5:0] d, output int a);
    wait_ready();
    in_data  = d;
    in_valid = 1'b1;
    @(posedge CLOCK_50);
    #1;
    a        = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge CLOCK_50);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    @(negedge CLOCK_50);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset values
    repeat (2) begin
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy",      {31'd0, busy},      32'd0);
      chk("rst_bcd",       {24'd0, bcd},       32'd0);
      chk("rst_seg",       {18'd0, seg},       {18'd0, UZ, 7'b1000000});
    end
    RST = 1'b0;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("in_ready_after_release", {31'd0, in_ready}, 32'd1);

    // 2: 31 with ready/latency timing
    sb_q.push_back({8'h31, 7'b0110000, 7'b1111001});
    send(6'd31, acc);
    for (int i = 0; i < 7; i++) begin
      @(negedge CLOCK_50);
      chk("in_ready_low", {31'd0, in_ready}, 32'd0);
      chk("busy_high",    {31'd0, busy},     32'd1);
    end
    @(negedge CLOCK_50);
    chk("in_ready_back", {31'd0, in_ready}, 32'd1);
    @(posedge CLOCK_50);
    #1;
    chk("pulse_count_31", ov_cyc.size(), 32'd1);
    if (ov_cyc.size() > 0) chk("latency", ov_cyc[$] - acc, 32'd7);
    drain();

    // 3: 63
    sb_q.push_back({8'h63, 7'b0000010, 7'b0110000});
    send(6'd63, acc);
    drain();

    // 4: held valid, 12 then 9, back-to-back
    n0 = ov_cyc.size();
    sb_q.push_back({8'h12, 7'b1111001, 7'b0100100});
    sb_q.push_back({8'h09, UZ, 7'b0010000});
    wait_ready();
    in_data  = 6'd12;
    in_valid = 1'b1;
    @(posedge CLOCK_50);
    #1;
    repeat (2) @(posedge CLOCK_50);
    #1;
    in_data = 6'd9;
    @(negedge CLOCK_50);
    wait_ready();
    @(posedge CLOCK_50);
    #1;
    in_valid = 1'b0;
    drain();
    chk("b2b_pulse_count", ov_cyc.size() - n0, 32'd2);
    if (ov_cyc.size() >= n0 + 2) chk("b2b_spacing", ov_cyc[$] - ov_cyc[$-1], 32'd8);

    // 5: reset in the 3rd SHIFT cycle aborts 45
    n0 = ov_cyc.size();
    send(6'd45, acc);
    repeat (2) @(posedge CLOCK_50);
    #1;
    RST = 1'b1;
    @(posedge CLOCK_50);
    #1;
    RST = 1'b0;
    @(negedge CLOCK_50);
    chk("abort_bcd",       {24'd0, bcd},       32'd0);
    chk("abort_seg",       {18'd0, seg},       {18'd0, UZ, 7'b1000000});
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (12) @(negedge CLOCK_50);
    chk("abort_no_pulse", ov_cyc.size() - n0, 32'd0);
    sb_q.push_back({8'h05, UZ, 7'b0010010});
    send(6'd5, acc);
    drain();

    // 6: leading-zero cases
    sb_q.push_back({8'h07, UZ, 7'b1111000});
    send(6'd7, acc);
    drain();
    sb_q.push_back({8'h00, UZ, 7'b1000000});
    send(6'd0, acc);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
